// File: rtl/fpu_req_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_req_arbiter
//
// Shares a single FPU core between NUM_REQ requesters. Requests are arbitrated
// round-robin and only one operation is in flight at a time. The winning
// request's operands are registered onto the FPU pins, a one-cycle start pulse
// is issued, and the arbiter waits for the FPU's ready. The result and flags
// are then returned on a shared response bus tagged with the requester index.
// If the FPU never answers, a watchdog forces an error response after TIMEOUT
// cycles in WAIT.
//
// Ports
//   clk, rst        clock (posedge) and asynchronous active-high reset
//   req_valid_i     per-requester request valid
//   req_ready_o     per-requester accept, one-hot for the single accept cycle
//   req_opa_i/opb_i packed operands, requester k at [k*DATA_W +: DATA_W]
//   req_op_i        packed 3-bit fpu_op per requester
//   req_rmode_i     packed 2-bit rounding mode per requester
//   fpu_*_o         operand/op/rmode/start pins driven into the FPU
//   fpu_ready_i     FPU result-ready
//   fpu_result_i    FPU result
//   fpu_flags_i     {ine,overflow,underflow,div_zero,inf,zero,qnan,snan}
//   rsp_valid_o     response valid, held until rsp_ready_i
//   rsp_ready_i     response consumer ready
//   rsp_id_o        index of the requester owning the response
//   rsp_result_o    captured result (0 on timeout)
//   rsp_flags_o     captured flags (0 on timeout)
//   rsp_timeout_o   1 when the response was forced by the watchdog
// -----------------------------------------------------------------------------
module fpu_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0]  req_opa_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_opb_i,
    input  logic [NUM_REQ*3-1:0]       req_op_i,
    input  logic [NUM_REQ*2-1:0]       req_rmode_i,
    output logic [DATA_W-1:0]          fpu_opa_o,
    output logic [DATA_W-1:0]          fpu_opb_o,
    output logic [2:0]                 fpu_op_o,
    output logic [1:0]                 fpu_rmode_o,
    output logic                       fpu_start_o,
    input  logic                       fpu_ready_i,
    input  logic [DATA_W-1:0]          fpu_result_i,
    input  logic [7:0]                 fpu_flags_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
    output logic [DATA_W-1:0]          rsp_result_o,
    output logic [7:0]                 rsp_flags_o,
    output logic                       rsp_timeout_o
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // One extra bit so rr_ptr + offset never overflows before the wrap.
    localparam logic [ID_W:0]    NREQ_EXT    = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_IDX    = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t           state_r;
    logic [ID_W-1:0]  rr_ptr_r;
    logic [ID_W-1:0]  owner_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;

    logic [ID_W-1:0]  grant_idx_s;
    logic             grant_vld_s;
    logic [ID_W:0]    cand_sum_s;
    logic [ID_W-1:0]  cand_idx_s;
    logic             cand_hit_s;

    assign cnt_inc_s = cnt_r + CNT_W'(1);

    // Round-robin pick: first valid requester at or after rr_ptr_r, wrapping at NUM_REQ.
    always_comb begin
        grant_idx_s = '0;
        grant_vld_s = 1'b0;
        cand_sum_s  = '0;
        cand_idx_s  = '0;
        cand_hit_s  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum_s  = {1'b0, rr_ptr_r} + (ID_W+1)'(i);
            cand_idx_s  = (cand_sum_s >= NREQ_EXT) ? ID_W'(cand_sum_s - NREQ_EXT)
                                                   : ID_W'(cand_sum_s);
            cand_hit_s  = req_valid_i[cand_idx_s] & ~grant_vld_s;
            grant_idx_s = cand_hit_s ? cand_idx_s : grant_idx_s;
            grant_vld_s = grant_vld_s | cand_hit_s;
        end
    end

    // Accept strobe: only while idle, and forced low while reset is asserted.
    always_comb begin
        req_ready_o = '0;
        if ((state_r == ST_IDLE) && grant_vld_s && !rst) begin
            req_ready_o[grant_idx_s] = 1'b1;
        end else begin
            req_ready_o = '0;
        end
    end

    // Control FSM with all FPU-side and response-side outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= '0;
            owner_r       <= '0;
            cnt_r         <= '0;
            fpu_opa_o     <= '0;
            fpu_opb_o     <= '0;
            fpu_op_o      <= 3'd0;
            fpu_rmode_o   <= 2'd0;
            fpu_start_o   <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_id_o      <= '0;
            rsp_result_o  <= '0;
            rsp_flags_o   <= 8'd0;
            rsp_timeout_o <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_vld_s) begin
                        fpu_opa_o   <= req_opa_i[grant_idx_s*DATA_W +: DATA_W];
                        fpu_opb_o   <= req_opb_i[grant_idx_s*DATA_W +: DATA_W];
                        fpu_op_o    <= req_op_i[grant_idx_s*3 +: 3];
                        fpu_rmode_o <= req_rmode_i[grant_idx_s*2 +: 2];
                        fpu_start_o <= 1'b1;
                        owner_r     <= grant_idx_s;
                        rr_ptr_r    <= (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + ID_W'(1);
                        state_r     <= ST_ISSUE;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // A ready still high from the previous op is deliberately not looked at here.
                    fpu_start_o <= 1'b0;
                    cnt_r       <= '0;
                    state_r     <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_r <= cnt_inc_s;
                    if (fpu_ready_i) begin
                        // Ready takes priority over a watchdog expiring in the same cycle.
                        rsp_result_o  <= fpu_result_i;
                        rsp_flags_o   <= fpu_flags_i;
                        rsp_timeout_o <= 1'b0;
                        rsp_id_o      <= owner_r;
                        rsp_valid_o   <= 1'b1;
                        state_r       <= ST_RESP;
                    end else if (cnt_inc_s == TIMEOUT_CNT) begin
                        rsp_result_o  <= '0;
                        rsp_flags_o   <= 8'd0;
                        rsp_timeout_o <= 1'b1;
                        rsp_id_o      <= owner_r;
                        rsp_valid_o   <= 1'b1;
                        state_r       <= ST_RESP;
                    end else begin
                        state_r       <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cnt_r       <= '0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    fpu_start_o <= 1'b0;
                    rsp_valid_o <= 1'b0;
                    cnt_r       <= '0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
